// File: rtl/alu_uart_master.sv
// Sends operand A, operand B and opcode as bytes over a UART FIFO pair, waits for the result byte.
// Optional response timeout: define ALU_UART_MASTER_TIMEOUT_EN.
module alu_uart_master #(
   parameter int BUS_SIZE       = 8,
   parameter int OP_SIZE        = 6,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic [BUS_SIZE-1:0] i_op_a,
   input  logic [BUS_SIZE-1:0] i_op_b,
   input  logic [OP_SIZE-1:0]  i_op_code,
   output logic [BUS_SIZE-1:0] o_tx_data,
   output logic                o_wr,
   input  logic                i_tx_full,
   input  logic [BUS_SIZE-1:0] i_rx_data,
   input  logic                i_rx_empty,
   output logic                o_rd,
   output logic                o_busy,
   output logic [BUS_SIZE-1:0] o_result,
   output logic                o_done,
   output logic                o_timeout
);

   typedef enum logic [2:0] {
      IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, DONE
   } state_t;

   state_t state, state_next;

   logic [BUS_SIZE-1:0] op_a, op_b;
   logic [OP_SIZE-1:0]  op_code;
   logic                time_up;

`ifdef ALU_UART_MASTER_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   assign time_up = (state == WAIT_RES) && i_rx_empty &&
                    (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (state == SEND_OP && !i_tx_full) begin
         tmo_cnt <= '0;
      end else if (state == WAIT_RES && i_rx_empty) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end
`else
   logic unused_tmo;

   assign unused_tmo = ^16'(TIMEOUT_CYCLES);
   assign time_up    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         op_code   <= '0;
         o_result  <= '0;
         o_timeout <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && i_start) begin
            op_a    <= i_op_a;
            op_b    <= i_op_b;
            op_code <= i_op_code;
         end
         // A byte present on the limit cycle takes priority over the timeout
         if (o_rd) begin
            o_result  <= i_rx_data;
            o_timeout <= 1'b0;
         end else if (time_up) begin
            o_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      o_tx_data  = '0;
      o_wr       = 1'b0;
      o_rd       = 1'b0;
      o_done     = 1'b0;
      o_busy     = 1'b1;
      case (state)
         IDLE: begin
            o_busy = 1'b0;
            if (i_start) state_next = SEND_A;
         end
         SEND_A: begin
            o_tx_data = op_a;
            o_wr      = ~i_tx_full;
            if (!i_tx_full) state_next = SEND_B;
         end
         SEND_B: begin
            o_tx_data = op_b;
            o_wr      = ~i_tx_full;
            if (!i_tx_full) state_next = SEND_OP;
         end
         SEND_OP: begin
            o_tx_data = BUS_SIZE'(op_code);
            o_wr      = ~i_tx_full;
            if (!i_tx_full) state_next = WAIT_RES;
         end
         WAIT_RES: begin
            o_rd = ~i_rx_empty;
            if (!i_rx_empty || time_up) state_next = DONE;
         end
         DONE: begin
            o_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_uart_master.sv
// Randomized bench for alu_uart_master against a transaction-level model.
// Timeout cases are exercised when ALU_UART_MASTER_TIMEOUT_EN is defined.
module tb_alu_uart_master;

   localparam int TMO = 16;
`ifdef ALU_UART_MASTER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       i_start;
   logic [7:0] i_op_a, i_op_b;
   logic [5:0] i_op_code;
   logic [7:0] o_tx_data;
   logic       o_wr;
   logic       i_tx_full;
   logic [7:0] i_rx_data;
   logic       i_rx_empty;
   logic       o_rd;
   logic       o_busy;
   logic [7:0] o_result;
   logic       o_done;
   logic       o_timeout;

   alu_uart_master #(
      .BUS_SIZE(8), .OP_SIZE(6), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .i_start(i_start), .i_op_a(i_op_a), .i_op_b(i_op_b),
      .i_op_code(i_op_code),
      .o_tx_data(o_tx_data), .o_wr(o_wr), .i_tx_full(i_tx_full),
      .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty), .o_rd(o_rd),
      .o_busy(o_busy), .o_result(o_result), .o_done(o_done),
      .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observed bus activity, sampled mid-cycle
   logic [7:0] wr_q[$];
   int         wr_cyc[$];
   int         cyc_g = 0;
   int         rd_cnt, rd_cyc, done_cnt, done_cyc, start_cyc, viol;

   always @(negedge clk) begin
      cyc_g++;
      if (reset) begin
         if (o_wr || o_rd || o_done || o_busy) viol++;
      end else begin
         if (o_wr) begin
            wr_q.push_back(o_tx_data);
            wr_cyc.push_back(cyc_g);
            if (i_tx_full) viol++;
         end
         if (o_rd) begin
            rd_cnt++;
            rd_cyc = cyc_g;
         end
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc_g;
         end
         if (o_wr && o_rd) viol++;
         if (!o_busy && (o_wr || o_rd || o_done)) viol++;
         if (i_start && !o_busy && start_cyc < 0) start_cyc = cyc_g;
      end
   end

   logic [7:0] exp_result = '0;

   task automatic clear_mon();
      wr_q.delete();
      wr_cyc.delete();
      rd_cnt    = 0;
      done_cnt  = 0;
      start_cyc = -1;
      viol      = 0;
      rd_cyc    = -1;
      done_cyc  = -1;
   endtask

   // mode 0: tx never full, 1: random full, 2: full for 4 cycles in SEND_B
   task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [5:0] op, input logic [7:0] rx,
                          input int mode, input int rx_wait,
                          input bit poke, input bit stale);
      int         waited = 0;
      int         stall  = 0;
      bit         exp_to;
      int         exp_done;
      logic [7:0] exp_b[3];
      exp_b[0] = a;
      exp_b[1] = b;
      exp_b[2] = {2'b00, op};
      exp_to   = TMO_EN && !stale && (rx_wait >= TMO);
      clear_mon();
      if (stale) begin
         @(posedge clk); #1;
         i_rx_data  = rx;
         i_rx_empty = 1'b0;
      end
      for (int c = 0; c < 300 && done_cnt == 0; c++) begin
         @(posedge clk); #1;
         i_start   = (c == 0) || (poke && c == 2);
         i_op_a    = (c == 0) ? a : 8'hFF;
         i_op_b    = (c == 0) ? b : 8'($urandom);
         i_op_code = (c == 0) ? op : 6'($urandom);
         case (mode)
            0: i_tx_full = 1'b0;
            1: i_tx_full = 1'($urandom_range(0, 1));
            default: begin
               i_tx_full = (wr_q.size() == 1) && (stall < 4);
               if (i_tx_full) stall++;
            end
         endcase
         i_rx_data = rx;
         if (wr_q.size() == 3) begin
            i_rx_empty = stale ? 1'b0 : !(waited >= rx_wait);
            waited++;
         end else begin
            i_rx_empty = !stale;
         end
      end
      i_start    = 1'b0;
      i_tx_full  = 1'b0;
      i_rx_empty = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      if (!exp_to) exp_result = rx;
      chk("tx_count", wr_q.size(), 3);
      for (int i = 0; i < wr_q.size() && i < 3; i++)
         chk($sformatf("tx_byte%0d", i), wr_q[i], exp_b[i]);
      chk("protocol_viol", viol, 0);
      chk("done_count", done_cnt, 1);
      chk("rd_count", rd_cnt, exp_to ? 0 : 1);
      chk("result", o_result, exp_result);
      chk("timeout", o_timeout, exp_to);
      chk("busy_after", o_busy, 0);
      if (wr_cyc.size() == 3) begin
         if (exp_to) exp_done = wr_cyc[2] + 1 + TMO;
         else if (stale) exp_done = wr_cyc[2] + 2;
         else exp_done = wr_cyc[2] + 2 + rx_wait;
         chk("done_cycle", done_cyc, exp_done);
         if (mode == 0) begin
            chk("wr_first", wr_cyc[0], start_cyc + 1);
            chk("wr_last", wr_cyc[2], start_cyc + 3);
         end
         if (mode == 2) chk("stall_b", wr_cyc[1], wr_cyc[0] + 5);
      end
   endtask

   // where 0: abort while stalled in SEND_A, 1: abort in WAIT_RES
   task automatic abort_cmd(input int where);
      int n_wr;
      clear_mon();
      @(posedge clk); #1;
      i_start   = 1'b1;
      i_op_a    = 8'h11;
      i_op_b    = 8'h22;
      i_op_code = 6'h33;
      i_tx_full = (where == 0);
      repeat (6) begin
         @(posedge clk); #1;
         i_start = 1'b0;
      end
      n_wr = wr_q.size();
      reset = 1'b1;
      #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_result", o_result, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_strobes", {o_wr, o_rd, o_done}, 0);
      @(posedge clk); #1;
      reset      = 1'b0;
      i_tx_full  = 1'b0;
      i_rx_data  = 8'h55;
      i_rx_empty = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      i_rx_empty = 1'b1;
      exp_result = '0;
      chk("abort_wr", wr_q.size(), n_wr);
      chk("abort_rd", rd_cnt, 0);
      chk("abort_done", done_cnt, 0);
      chk("abort_viol", viol, 0);
   endtask

   initial begin
      reset      = 1'b1;
      i_start    = 1'b0;
      i_op_a     = '0;
      i_op_b     = '0;
      i_op_code  = '0;
      i_tx_full  = 1'b0;
      i_rx_data  = '0;
      i_rx_empty = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", o_busy, 0);
      chk("reset_result", o_result, 0);
      chk("reset_timeout", o_timeout, 0);
      chk("reset_strobes", {o_wr, o_rd, o_done}, 0);
      reset = 1'b0;

      run_cmd(8'h05, 8'h03, 6'h20, 8'h08, 0, 2, 1'b0, 1'b0);
      run_cmd(8'h05, 8'h03, 6'h20, 8'h08, 2, 0, 1'b0, 1'b0);
      run_cmd(8'h05, 8'h03, 6'h20, 8'h08, 0, 1, 1'b1, 1'b0);
      if (TMO_EN) begin
         run_cmd(8'hA1, 8'hB2, 6'h3F, 8'h77, 0, 1000, 1'b0, 1'b0);
         run_cmd(8'h01, 8'h02, 6'h03, 8'h9C, 0, TMO - 1, 1'b0, 1'b0);
         run_cmd(8'h04, 8'h05, 6'h06, 8'h4D, 1, TMO, 1'b0, 1'b0);
      end else begin
         run_cmd(8'hA1, 8'hB2, 6'h3F, 8'h77, 0, 40, 1'b0, 1'b0);
      end
      run_cmd(8'hC3, 8'h3C, 6'h15, 8'hE7, 1, 0, 1'b0, 1'b1);
      abort_cmd(1);
      run_cmd(8'h12, 8'h34, 6'h2A, 8'h5A, 0, 0, 1'b0, 1'b0);
      abort_cmd(0);
      for (int k = 0; k < 20; k++)
         run_cmd(8'($urandom), 8'($urandom), 6'($urandom), 8'($urandom),
                 1, $urandom_range(0, 8), 1'($urandom), 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_uart_master.md
ALU_UART_MASTER -- requirements
Module: alu_uart_master

Interface
REQ-001 The block SHALL have parameter BUS_SIZE, default 8, data byte width.
REQ-002 The block SHALL have parameter OP_SIZE, default 6, opcode width; OP_SIZE <= BUS_SIZE.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, response wait limit in clk cycles; 1..65535.
REQ-004 The block SHALL have ports: clk  input  1  clock; reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports: i_start  input  1  command request; i_op_a  input  BUS_SIZE  operand A; i_op_b  input  BUS_SIZE  operand B; i_op_code  input  OP_SIZE  opcode.
REQ-006 The block SHALL have ports: o_tx_data  output  BUS_SIZE  byte to TX FIFO; o_wr  output  1  TX FIFO push; i_tx_full  input  1  TX FIFO full.
REQ-007 The block SHALL have ports: i_rx_data  input  BUS_SIZE  RX FIFO head byte; i_rx_empty  input  1  RX FIFO empty; o_rd  output  1  RX FIFO pop.
REQ-008 The block SHALL have ports: o_busy  output  1  command in progress; o_result  output  BUS_SIZE  last result; o_done  output  1  completion pulse; o_timeout  output  1  completion was a timeout.

Function
REQ-009 FSM states SHALL be IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, DONE; state register updated on posedge clk.
REQ-010 On rising clk edge in IDLE with i_start=1, the block SHALL latch i_op_a, i_op_b, i_op_code and go to SEND_A.
REQ-011 i_start SHALL be ignored in every state other than IDLE.
REQ-012 o_busy SHALL be 1 in every state except IDLE.
REQ-013 In SEND_A/SEND_B/SEND_OP: o_wr = ~i_tx_full (combinational from state and i_tx_full); o_tx_data = latched A / latched B / {zero pad, latched opcode} respectively.
REQ-014 Each SEND state SHALL advance (A->B->OP->WAIT_RES) only on an edge where o_wr=1; while i_tx_full=1 it holds, o_wr=0, byte not lost or duplicated.
REQ-015 With i_tx_full constantly 0, o_wr SHALL be high exactly 3 consecutive cycles, starting the cycle after i_start sampled.
REQ-016 In WAIT_RES: o_rd = ~i_rx_empty; on an edge with o_rd=1, o_result <= i_rx_data, o_timeout <= 0, state -> DONE.
REQ-017 In IDLE and SEND states o_rd SHALL be 0; stale RX bytes are not consumed.
REQ-018 DONE SHALL last exactly one cycle with o_done=1, then go to IDLE; o_done SHALL be 0 in all other states.
REQ-019 o_result and o_timeout SHALL hold value until next completion.
REQ-020 o_wr and o_rd SHALL never both be 1 in the same cycle.

Reset
REQ-021 Reset assertion SHALL immediately force state IDLE, o_result=0, o_timeout=0, latched operands=0, timeout counter=0; o_wr, o_rd, o_done, o_busy=0.
REQ-022 Reset mid-command SHALL abort it with no further o_wr/o_rd pulses and no o_done.

Configuration
REQ-023 With macro ALU_UART_MASTER_TIMEOUT_EN defined: a 16-bit counter clears on WAIT_RES entry, increments each WAIT_RES cycle with i_rx_empty=1; when it reaches TIMEOUT_CYCLES-1 with i_rx_empty=1, state -> DONE, o_timeout <= 1, o_result unchanged.
REQ-024 With ALU_UART_MASTER_TIMEOUT_EN defined, if i_rx_empty=0 on the limit cycle, the byte SHALL be read and o_timeout=0 (data wins).
REQ-025 Without ALU_UART_MASTER_TIMEOUT_EN: no counter, WAIT_RES waits indefinitely, o_timeout constant 0.

Verification
REQ-026 A=0x05, B=0x03, op=0x20, tx_full=0; rx returns 0x08 -> TX bytes 0x05,0x03,0x20 on 3 consecutive cycles, one o_rd, o_result=0x08, single o_done, o_timeout=0.
REQ-027 i_tx_full high 4 cycles during SEND_B -> o_wr low those 4 cycles, sequence still exactly 0x05,0x03,0x20.
REQ-028 i_start pulsed again while busy with A=0xFF -> ignored; TX sequence unchanged, one o_done.
REQ-029 TIMEOUT_EN defined, TIMEOUT_CYCLES=16, rx stays empty -> o_done 16 cycles after WAIT_RES entry, o_timeout=1, o_result keeps previous 0x08, o_rd never asserted.
REQ-030 Reset asserted in WAIT_RES -> o_busy=0 immediately, o_result=0, no o_done; next command completes normally.
